edge_list_decoder: RTL and testbench
====================================

# edge_list_decoder

Parses the raw ASCII puzzle input, one byte per cycle, into per-node 15-bit letter codes. It sits directly upstream of the node-index mapping stage. For each line it emits one source-node strobe, then one edge strobe per destination, and a final end-of-input flag. It never asserts the source and edge strobes in the same cycle, which the downstream mapper requires.

## Interface
- `NODE_STR_WIDTH`, 15, node code width; fixed, do not override.
- `EDGE_CNT_WIDTH`, 16, width of the edge counter.
- `clk` input 1: single clock.
- `rst` input 1: reset; synchronous, active-high. One clock; reset is synchronous and active-high.
- `inbound_byte` input 8: input character.
- `inbound_valid` input 1: `inbound_byte` valid this cycle. Gaps are allowed; there is no backpressure.
- `src_node_str_valid` output 1: one-cycle pulse, new source node.
- `edge_str_valid` output 1: one-cycle pulse, new edge from `src_node_str` to `dst_node_str`.
- `src_node_str` output 15: current line's source code; held until the next source pulse.
- `dst_node_str` output 15: latest destination code; held until the next edge pulse.
- `decoding_done_str` output 1: sticky; end-of-input reached.
- `parse_error` output 1: sticky; malformed input detected.
- `edge_cnt` output `EDGE_CNT_WIDTH`: number of edges emitted; saturates at all-ones.

## Operation
- Input grammar per line: `sss: ddd ddd ... ddd` followed by LF.
  - Every token is exactly three chars in `a`–`z`.
  - Exactly one space separates tokens, including after the colon.
- CR (0x0D) is ignored in every state.
- NUL (0x00) marks end-of-input.
- Letter encoding: 1st char minus 0x61 goes to bits [4:0], 2nd to [9:5], 3rd to [14:10].
- States:
  - LINE_START
    - letter: shift in, go to SRC.
    - NUL: go to DONE.
    - LF: stay (blank lines are tolerated).
    - anything else: ERROR.
  - SRC: collect letters to 3.
    - On the 3rd letter, go to COLON.
    - Any non-letter before 3 letters: ERROR.
  - COLON
    - `:`: pulse `src_node_str_valid` with the assembled code, go to SEP.
    - else: ERROR.
  - SEP
    - space: go to DST.
    - LF: go to LINE_START (a line with zero destinations is legal).
    - else: ERROR.
  - DST: collect letters to 3, then go to DST_END.
    - Non-letter before 3 letters: ERROR.
  - DST_END
    - space: pulse `edge_str_valid`, go to DST.
    - LF: pulse `edge_str_valid`, go to LINE_START.
    - NUL: pulse `edge_str_valid`, go to DONE.
    - else: ERROR.
  - DONE: set `decoding_done_str`; all further bytes are ignored.
  - ERROR: set `parse_error`; all further bytes are ignored.
    - `decoding_done_str` is never set from ERROR.
- A char counter (0..3) resets at every delimiter.
- The shift register assembling a token is cleared at token start.
- `edge_cnt` increments on each edge pulse.

## Timing
- Reset values: all outputs 0. State is LINE_START, char counter 0.
- All outputs are registered.
- A strobe asserts in the cycle after the delimiter byte is accepted:
  - `:` for `src_node_str_valid`;
  - space, LF or NUL for `edge_str_valid`.
- Data accompanying a strobe is valid in the strobe cycle and stable until the next strobe of the same kind.
- `edge_cnt` updates in the same cycle as `edge_str_valid`.
- `decoding_done_str` rises in the cycle after NUL is accepted.
  - When NUL terminates a destination, it rises in the same cycle as that final `edge_str_valid`.
- Mutual exclusion of the two strobes is inherent: each strobe needs a distinct delimiter byte.
- `inbound_valid` low: no state change, strobes deasserted.
- Reset mid-line: the partial line is discarded. No strobe is issued in the cycle after reset.
- Throughput: one byte per cycle, sustained.

## Structure
- A shared package holds:
  - `NODE_STR_WIDTH`;
  - `node_str_t`;
  - ASCII constants: `a`, `:`, space, LF, CR, NUL;
  - the letter-to-5-bit conversion function (also used by the mapper for its start/end constants).
- State enum is local to this module.
- No sub-module: a single FSM with a 15-bit shift register and a 2-bit char counter.

## Test plan
- `you: bbb out` LF NUL:
  - src pulse with 0x51D8;
  - edges 0x0421 then 0x4E8E;
  - done one cycle after NUL;
  - `edge_cnt`=2.
- `aaa: bbb` CR LF `bbb: out` NUL with one-cycle `inbound_valid` gaps:
  - src 0x0000, edge 0x0421;
  - src 0x0421, edge 0x4E8E;
  - done and final edge in the same cycle;
  - strobes never overlap.
- `aaa:` LF NUL:
  - one src pulse, no edge;
  - done set;
  - `edge_cnt`=0.
- `ab: ccc` LF:
  - `parse_error` set at `:`;
  - no strobes;
  - later bytes and NUL ignored;
  - done stays 0.
- `rst` asserted after `aaa: bb`, then `out: you` LF NUL:
  - all outputs 0 the cycle after reset;
  - src 0x4E8E, edge 0x51D8;
  - `edge_cnt`=1.

Source files
------------

// File: rtl/edge_list_decoder_pkg.sv
// Shared definitions for the edge-list parsing path.
// Holds the node code width and type, the ASCII constants the parser reacts to,
// and the letter-to-5-bit conversion that the node-index mapper also uses for
// its start/end constants.
package edge_list_decoder_pkg;

    localparam int unsigned NODE_STR_WIDTH = 15;

    typedef logic [NODE_STR_WIDTH-1:0] node_str_t;

    localparam logic [7:0] AsciiA     = 8'h61;
    localparam logic [7:0] AsciiZ     = 8'h7a;
    localparam logic [7:0] AsciiColon = 8'h3a;
    localparam logic [7:0] AsciiSpace = 8'h20;
    localparam logic [7:0] AsciiLf    = 8'h0a;
    localparam logic [7:0] AsciiCr    = 8'h0d;
    localparam logic [7:0] AsciiNul   = 8'h00;

    // 'a'..'z' -> 0..25
    function automatic logic [4:0] letter_to_code(input logic [7:0] c);
        logic [7:0] diff;
        diff = c - AsciiA;
        return diff[4:0];
    endfunction

    function automatic logic is_letter(input logic [7:0] c);
        return (c >= AsciiA) && (c <= AsciiZ);
    endfunction

endpackage

// File: rtl/edge_list_decoder.sv
// Byte-serial parser for "sss: ddd ddd ... ddd<LF>" lines terminated by NUL.
// Emits one src_node_str_valid pulse per line and one edge_str_valid pulse per
// destination; all outputs are registered.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   inbound_byte/_valid   input character stream, no backpressure
//   src_node_str_valid    pulse: src_node_str holds a new source code
//   edge_str_valid        pulse: dst_node_str holds a new destination code
//   src_node_str          current line's source code (3 x 5-bit, 1st char in LSBs)
//   dst_node_str          latest destination code
//   decoding_done_str     sticky, end-of-input reached
//   parse_error           sticky, malformed input
//   edge_cnt              edges emitted, saturating
module edge_list_decoder
    import edge_list_decoder_pkg::*;
#(
    parameter int unsigned EDGE_CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                inbound_byte,
    input  logic                      inbound_valid,
    output logic                      src_node_str_valid,
    output logic                      edge_str_valid,
    output logic [NODE_STR_WIDTH-1:0] src_node_str,
    output logic [NODE_STR_WIDTH-1:0] dst_node_str,
    output logic                      decoding_done_str,
    output logic                      parse_error,
    output logic [EDGE_CNT_WIDTH-1:0] edge_cnt
);

    typedef enum logic [2:0] {
        StLineStart, StSrc, StColon, StSep, StDst, StDstEnd, StDone, StError
    } state_e;

    state_e                    state_q, state_d;
    logic [1:0]                cnt_q, cnt_d;
    node_str_t                 shift_q, shift_d;
    node_str_t                 src_q, src_d;
    node_str_t                 dst_q, dst_d;
    logic                      src_vld_q, src_vld_d;
    logic                      edge_vld_q, edge_vld_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;
    logic [EDGE_CNT_WIDTH-1:0] edge_cnt_q, edge_cnt_d;

    logic      letter;
    node_str_t shifted;
    node_str_t first;

    always_comb begin
        letter  = is_letter(inbound_byte);
        // Later chars enter at the top so the 1st char ends up in [4:0].
        shifted = {letter_to_code(inbound_byte), shift_q[NODE_STR_WIDTH-1:5]};
        first   = {letter_to_code(inbound_byte), 10'b0};

        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        src_d      = src_q;
        dst_d      = dst_q;
        src_vld_d  = 1'b0;
        edge_vld_d = 1'b0;
        done_d     = done_q;
        err_d      = err_q;
        edge_cnt_d = edge_cnt_q;

        if (inbound_valid && (inbound_byte != AsciiCr)) begin
            unique case (state_q)
                StLineStart: begin
                    if (letter) begin
                        shift_d = first;
                        cnt_d   = 2'd1;
                        state_d = StSrc;
                    end else if (inbound_byte == AsciiNul) begin
                        done_d  = 1'b1;
                        state_d = StDone;
                    end else if (inbound_byte != AsciiLf) begin
                        err_d   = 1'b1;
                        state_d = StError;
                    end
                end
                StSrc: begin
                    if (letter) begin
                        shift_d = shifted;
                        if (cnt_q == 2'd2) begin
                            cnt_d   = 2'd0;
                            state_d = StColon;
                        end else begin
                            cnt_d = cnt_q + 2'd1;
                        end
                    end else begin
                        err_d   = 1'b1;
                        state_d = StError;
                    end
                end
                StColon: begin
                    if (inbound_byte == AsciiColon) begin
                        src_d     = shift_q;
                        src_vld_d = 1'b1;
                        state_d   = StSep;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StError;
                    end
                end
                StSep: begin
                    if (inbound_byte == AsciiSpace) begin
                        cnt_d   = 2'd0;
                        state_d = StDst;
                    end else if (inbound_byte == AsciiLf) begin
                        cnt_d   = 2'd0;
                        state_d = StLineStart;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StError;
                    end
                end
                StDst: begin
                    if (letter) begin
                        shift_d = (cnt_q == 2'd0) ? first : shifted;
                        if (cnt_q == 2'd2) begin
                            cnt_d   = 2'd0;
                            state_d = StDstEnd;
                        end else begin
                            cnt_d = cnt_q + 2'd1;
                        end
                    end else begin
                        err_d   = 1'b1;
                        state_d = StError;
                    end
                end
                StDstEnd: begin
                    if ((inbound_byte == AsciiSpace) || (inbound_byte == AsciiLf) ||
                        (inbound_byte == AsciiNul)) begin
                        dst_d      = shift_q;
                        edge_vld_d = 1'b1;
                        cnt_d      = 2'd0;
                        if (edge_cnt_q != '1) begin
                            edge_cnt_d = edge_cnt_q + EDGE_CNT_WIDTH'(1);
                        end
                        if (inbound_byte == AsciiSpace) begin
                            state_d = StDst;
                        end else if (inbound_byte == AsciiLf) begin
                            state_d = StLineStart;
                        end else begin
                            done_d  = 1'b1;
                            state_d = StDone;
                        end
                    end else begin
                        err_d   = 1'b1;
                        state_d = StError;
                    end
                end
                StDone, StError: ;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StLineStart;
            cnt_q      <= 2'd0;
            shift_q    <= '0;
            src_q      <= '0;
            dst_q      <= '0;
            src_vld_q  <= 1'b0;
            edge_vld_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            edge_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            src_vld_q  <= src_vld_d;
            edge_vld_q <= edge_vld_d;
            done_q     <= done_d;
            err_q      <= err_d;
            edge_cnt_q <= edge_cnt_d;
        end
    end

    assign src_node_str_valid = src_vld_q;
    assign edge_str_valid     = edge_vld_q;
    assign src_node_str       = src_q;
    assign dst_node_str       = dst_q;
    assign decoding_done_str  = done_q;
    assign parse_error        = err_q;
    assign edge_cnt           = edge_cnt_q;

endmodule

// File: tb/tb_edge_list_decoder.sv
// Directed bench for edge_list_decoder: one byte per step, outputs sampled 1ns
// after the clock edge that accepted the byte.
module tb_edge_list_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  inbound_byte = 8'h00;
    logic        inbound_valid = 1'b0;
    logic        src_node_str_valid;
    logic        edge_str_valid;
    logic [14:0] src_node_str;
    logic [14:0] dst_node_str;
    logic        decoding_done_str;
    logic        parse_error;
    logic [15:0] edge_cnt;

    int total = 0;
    int bad   = 0;
    int src_pulses = 0;
    int edge_pulses = 0;
    int overlaps = 0;
    int base_src;
    int base_edge;

    edge_list_decoder #(.EDGE_CNT_WIDTH(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .inbound_byte      (inbound_byte),
        .inbound_valid     (inbound_valid),
        .src_node_str_valid(src_node_str_valid),
        .edge_str_valid    (edge_str_valid),
        .src_node_str      (src_node_str),
        .dst_node_str      (dst_node_str),
        .decoding_done_str (decoding_done_str),
        .parse_error       (parse_error),
        .edge_cnt          (edge_cnt)
    );

    always #5 clk = ~clk;

    // Strobe bookkeeping, sampled away from the active edge.
    always @(negedge clk) begin
        if (src_node_str_valid) src_pulses++;
        if (edge_str_valid) edge_pulses++;
        if (src_node_str_valid && edge_str_valid) overlaps++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        inbound_byte  = b;
        inbound_valid = 1'b1;
        @(posedge clk);
        #1;
        inbound_valid = 1'b0;
    endtask

    // Idle cycle with a NUL on the bus that must be ignored.
    task automatic gap();
        inbound_byte  = 8'h00;
        inbound_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_srcv"}, 32'(src_node_str_valid), 32'h0);
        chk({tag, "_edgev"}, 32'(edge_str_valid), 32'h0);
        chk({tag, "_src"}, 32'(src_node_str), 32'h0);
        chk({tag, "_dst"}, 32'(dst_node_str), 32'h0);
        chk({tag, "_done"}, 32'(decoding_done_str), 32'h0);
        chk({tag, "_err"}, 32'(parse_error), 32'h0);
        chk({tag, "_cnt"}, 32'(edge_cnt), 32'h0);
    endtask

    initial begin
        string s2;

        // ---- 1: "you: bbb out\n" NUL
        do_reset();
        chk_zero("rst1");
        send_str("you");
        chk("t1_no_src_early", 32'(src_node_str_valid), 32'h0);
        send(":");
        chk("t1_srcv", 32'(src_node_str_valid), 32'h1);
        chk("t1_src", 32'(src_node_str), 32'h51d8);
        send_str(" bbb");
        chk("t1_srcv_drop", 32'(src_node_str_valid), 32'h0);
        chk("t1_no_edge_early", 32'(edge_str_valid), 32'h0);
        send(" ");
        chk("t1_e1v", 32'(edge_str_valid), 32'h1);
        chk("t1_e1", 32'(dst_node_str), 32'h0421);
        chk("t1_cnt1", 32'(edge_cnt), 32'h1);
        send_str("out");
        chk("t1_dst_held", 32'(dst_node_str), 32'h0421);
        send(8'h0a);
        chk("t1_e2v", 32'(edge_str_valid), 32'h1);
        chk("t1_e2", 32'(dst_node_str), 32'h4e8e);
        chk("t1_done_not_yet", 32'(decoding_done_str), 32'h0);
        send(8'h00);
        chk("t1_done", 32'(decoding_done_str), 32'h1);
        chk("t1_no_edge_at_nul", 32'(edge_str_valid), 32'h0);
        chk("t1_cnt2", 32'(edge_cnt), 32'h2);
        chk("t1_src_held", 32'(src_node_str), 32'h51d8);
        chk("t1_err", 32'(parse_error), 32'h0);

        // ---- 2: "aaa: bbb\r\nbbb: out" NUL, gap after every byte
        do_reset();
        chk_zero("rst2");
        base_src  = src_pulses;
        base_edge = edge_pulses;
        s2 = {"aaa: bbb", 8'h0d, 8'h0a, "bbb: out"};
        for (int i = 0; i < s2.len(); i++) begin
            send(s2[i]);
            if (i == 3) begin
                chk("t2_src1v", 32'(src_node_str_valid), 32'h1);
                chk("t2_src1", 32'(src_node_str), 32'h0000);
            end
            if (i == 9) begin
                chk("t2_e1v", 32'(edge_str_valid), 32'h1);
                chk("t2_e1", 32'(dst_node_str), 32'h0421);
            end
            if (i == 13) begin
                chk("t2_src2v", 32'(src_node_str_valid), 32'h1);
                chk("t2_src2", 32'(src_node_str), 32'h0421);
            end
            gap();
            if (i == 3) chk("t2_gap_drop", 32'(src_node_str_valid), 32'h0);
        end
        send(8'h00);
        chk("t2_e2v", 32'(edge_str_valid), 32'h1);
        chk("t2_e2", 32'(dst_node_str), 32'h4e8e);
        chk("t2_done_same", 32'(decoding_done_str), 32'h1);
        chk("t2_cnt", 32'(edge_cnt), 32'h2);
        gap();
        chk("t2_src_pulses", 32'(src_pulses - base_src), 32'h2);
        chk("t2_edge_pulses", 32'(edge_pulses - base_edge), 32'h2);
        chk("t2_overlap", 32'(overlaps), 32'h0);

        // ---- 3: "aaa:\n" NUL
        do_reset();
        base_src  = src_pulses;
        base_edge = edge_pulses;
        send_str({"aaa:", 8'h0a});
        send(8'h00);
        gap();
        chk("t3_src_pulses", 32'(src_pulses - base_src), 32'h1);
        chk("t3_edge_pulses", 32'(edge_pulses - base_edge), 32'h0);
        chk("t3_done", 32'(decoding_done_str), 32'h1);
        chk("t3_cnt", 32'(edge_cnt), 32'h0);
        chk("t3_err", 32'(parse_error), 32'h0);

        // ---- 4: "ab: ccc\n" NUL -> error at ':'
        do_reset();
        base_src  = src_pulses;
        base_edge = edge_pulses;
        send_str("ab");
        chk("t4_err_not_yet", 32'(parse_error), 32'h0);
        send(":");
        chk("t4_err", 32'(parse_error), 32'h1);
        send_str({" ccc", 8'h0a});
        send(8'h00);
        gap();
        chk("t4_err_sticky", 32'(parse_error), 32'h1);
        chk("t4_done", 32'(decoding_done_str), 32'h0);
        chk("t4_src_pulses", 32'(src_pulses - base_src), 32'h0);
        chk("t4_edge_pulses", 32'(edge_pulses - base_edge), 32'h0);

        // ---- 5: reset mid-line after "aaa: bb", then "out: you\n" NUL
        do_reset();
        send_str("aaa: bb");
        inbound_byte  = "b";
        inbound_valid = 1'b1;
        do_reset();
        inbound_valid = 1'b0;
        chk_zero("rst5");
        send_str("out:");
        chk("t5_srcv", 32'(src_node_str_valid), 32'h1);
        chk("t5_src", 32'(src_node_str), 32'h4e8e);
        send_str(" you");
        send(8'h0a);
        chk("t5_ev", 32'(edge_str_valid), 32'h1);
        chk("t5_e", 32'(dst_node_str), 32'h51d8);
        send(8'h00);
        chk("t5_cnt", 32'(edge_cnt), 32'h1);
        chk("t5_done", 32'(decoding_done_str), 32'h1);
        chk("t5_err", 32'(parse_error), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
